// File: rtl/hack_uart_rx.sv
// Memory-mapped 8N1 UART receiver for the Hack I/O page: deserialises uart_rx into a byte FIFO
// read through DATA/STATUS registers. Define HACK_UART_RX_PARITY_EN for 8E1 framing with a perr flag.
module hack_uart_rx #(
    parameter int          CLK_HZ      = 27000000,
    parameter int          BAUD        = 115200,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DATA_ADDR   = 16'h6003,
    parameter logic [15:0] STATUS_ADDR = 16'h6002
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    input  logic [15:0] address_m,
    input  logic [15:0] out_m,
    input  logic        load_m,
    output logic [15:0] rd_data,
    output logic        rd_hit,
    output logic [2:0]  dbg_state_o
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    // IDLE spends one cycle detecting the falling edge, so the start reload is one short
    // to land the start-bit sample DIV/2 cycles after rx_s falls.
    localparam logic [15:0] START_LOAD = 16'(DIV / 2 - 2);
    localparam logic [15:0] BIT_LOAD   = 16'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    // Handshake: the receiver offers a byte for exactly one cycle (push); the FIFO always
    // accepts it unless full with no pop, in which case the byte is dropped and ovf is set.

    logic        rx_meta_q;
    logic        rx_s_q;
    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  sh_q;
    logic        par_bad_q;

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0] count_q;
    logic        ovf_q;
    logic        ferr_q;
    logic        perr;

    logic        is_data;
    logic        is_status;
    logic        not_empty;
    logic        full;
    logic        pop;
    logic        clr;
    logic        stop_tick;
    logic        push;
    logic        push_ok;
    logic        ovf_evt;
    logic        ferr_evt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            bit_q     <= 3'd0;
            sh_q      <= 8'd0;
            par_bad_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        cnt_q   <= START_LOAD;
                    end
                end
                S_START: begin
                    if (cnt_q == 16'd0) begin
                        if (!rx_s_q) begin
                            state_q   <= S_DATA;
                            cnt_q     <= BIT_LOAD;
                            bit_q     <= 3'd0;
                            par_bad_q <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            cnt_q   <= 16'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == 16'd0) begin
                        sh_q  <= {rx_s_q, sh_q[7:1]};
                        cnt_q <= BIT_LOAD;
                        if (bit_q == 3'd7) begin
`ifdef HACK_UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_PARITY: begin
                    if (cnt_q == 16'd0) begin
                        par_bad_q <= (^sh_q) != rx_s_q;
                        state_q   <= S_STOP;
                        cnt_q     <= BIT_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= rx_s_q ? S_IDLE : S_WAIT_IDLE;
                        cnt_q   <= 16'd0;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 16'd0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 16'd0;
                end
            endcase
        end
    end

    assign dbg_state_o = state_q;

    assign is_data   = (address_m == DATA_ADDR);
    assign is_status = (address_m == STATUS_ADDR);
    assign not_empty = (count_q != '0);
    assign full      = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign pop       = load_m && is_data && not_empty;
    assign clr       = load_m && is_status;
    assign stop_tick = (state_q == S_STOP) && (cnt_q == 16'd0);
    assign push      = stop_tick && rx_s_q && !par_bad_q;
    assign ferr_evt  = stop_tick && !rx_s_q;
    // A pop in the same cycle frees the slot first, so a push into a full FIFO still lands.
    assign push_ok   = push && (!full || pop);
    assign ovf_evt   = push && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= sh_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (pop && !push_ok) begin
                count_q <= count_q - (AW + 1)'(1);
            end
        end
    end

    // Sticky flags: a clear and a new event in the same cycle leave the flag set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovf_q  <= (ovf_q  & ~(clr & out_m[1])) | ovf_evt;
            ferr_q <= (ferr_q & ~(clr & out_m[2])) | ferr_evt;
        end
    end

`ifdef HACK_UART_RX_PARITY_EN
    logic perr_q;
    logic perr_evt;
    logic unused_bits;

    assign perr_evt    = (state_q == S_PARITY) && (cnt_q == 16'd0) && ((^sh_q) != rx_s_q);
    assign perr        = perr_q;
    assign unused_bits = ^{out_m[15:4], out_m[0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= (perr_q & ~(clr & out_m[3])) | perr_evt;
        end
    end
`else
    logic unused_bits;

    assign perr        = 1'b0;
    assign unused_bits = ^{out_m[15:3], out_m[0], par_bad_q};
`endif

    always_comb begin
        rd_data = 16'h0000;
        rd_hit  = is_data || is_status;
        if (is_data) begin
            if (not_empty) begin
                rd_data = {8'h00, mem_q[rd_ptr_q]};
            end
        end else if (is_status) begin
            rd_data = {12'b0, perr, ferr_q, ovf_q, not_empty};
        end
    end

endmodule

// File: tb/tb_hack_uart_rx.sv
// Directed bench for hack_uart_rx: a queue-level model of the byte FIFO and sticky flags,
// checked every cycle, plus hand-computed literal expectations for each scenario.
module tb_hack_uart_rx;

    localparam int          CLK_HZ = 1000000;
    localparam int          BAUD   = 100000;
    localparam int          DEPTH  = 16;
    localparam logic [15:0] DATA_A = 16'h6003;
    localparam logic [15:0] STAT_A = 16'h6002;
    // uart_rx low after the negedge of cycle P -> two sync flops -> stop sample at posedge P+97.
    localparam int          PUSH_LAT = 97;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        uart_rx   = 1'b1;
    logic [15:0] address_m = STAT_A;
    logic [15:0] out_m     = 16'h0000;
    logic        load_m    = 1'b0;
    logic [15:0] rd_data;
    logic        rd_hit;
    logic [2:0]  dbg_state;

    hack_uart_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH),
        .DATA_ADDR  (DATA_A),
        .STATUS_ADDR(STAT_A)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .address_m  (address_m),
        .out_m      (out_m),
        .load_m     (load_m),
        .rd_data    (rd_data),
        .rd_hit     (rd_hit),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         at;
        logic       good;
        logic [7:0] b;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] exp_q[$];
    logic       m_ovf  = 1'b0;
    logic       m_ferr = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: frame completions are scheduled by the driver; pop applies before push.
    always @(posedge clk) begin : model
        logic pop_m;
        logic clr_m;
        logic e_ovf;
        logic e_ferr;
        ev_t  e;
        cyc++;
        if (!reset) begin
            exp_q.delete();
            ev_q.delete();
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
        end else begin
            pop_m  = load_m && (address_m == DATA_A);
            clr_m  = load_m && (address_m == STAT_A);
            e_ovf  = 1'b0;
            e_ferr = 1'b0;
            if (pop_m && exp_q.size() > 0) void'(exp_q.pop_front());
            while (ev_q.size() > 0 && ev_q[0].at == cyc) begin
                e = ev_q.pop_front();
                if (!e.good) e_ferr = 1'b1;
                else if (exp_q.size() < DEPTH) exp_q.push_back(e.b);
                else e_ovf = 1'b1;
            end
            m_ovf  = (m_ovf  && !(clr_m && out_m[1])) || e_ovf;
            m_ferr = (m_ferr && !(clr_m && out_m[2])) || e_ferr;
        end
    end

    always @(posedge clk) begin : compare
        logic [15:0] e_data;
        #1;
        e_data = 16'h0000;
        if (address_m == DATA_A && exp_q.size() > 0) e_data = {8'h00, exp_q[0]};
        else if (address_m == STAT_A) e_data = {13'b0, m_ferr, m_ovf, exp_q.size() > 0};
        check("cyc_rd_data", rd_data, e_data);
        check("cyc_rd_hit", {15'b0, rd_hit}, {15'b0, (address_m == DATA_A) || (address_m == STAT_A)});
    end

    task automatic send_byte(input logic [7:0] b, input logic stop, input int extra_bits);
        @(negedge clk);
        ev_q.push_back('{at: cyc + PUSH_LAT, good: stop, b: b});
        uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (10) @(negedge clk);
        end
        uart_rx = stop;
        repeat (10 + 10 * extra_bits) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic read_check(input logic [15:0] addr, input logic [15:0] exp, input string name);
        @(negedge clk);
        address_m = addr;
        #1;
        check(name, rd_data, exp);
    endtask

    task automatic pop_check(input logic [7:0] exp, input string name);
        @(negedge clk);
        address_m = DATA_A;
        #1;
        check(name, rd_data, {8'h00, exp});
        load_m = 1'b1;
        @(negedge clk);
        load_m    = 1'b0;
        address_m = STAT_A;
    endtask

    task automatic write_reg(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        address_m = addr;
        out_m     = data;
        load_m    = 1'b1;
        @(negedge clk);
        load_m    = 1'b0;
        out_m     = 16'h0000;
        address_m = STAT_A;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b1;
        read_check(STAT_A, 16'h0000, "rst_status");
        check("rst_hit_status", {15'b0, rd_hit}, 16'h0001);
        read_check(DATA_A, 16'h0000, "rst_data");
        check("rst_hit_data", {15'b0, rd_hit}, 16'h0001);
        read_check(16'h6000, 16'h0000, "rst_kbd");
        check("rst_hit_kbd", {15'b0, rd_hit}, 16'h0000);
        address_m = STAT_A;

        // Single byte with exact push latency
        fork
            send_byte(8'hA5, 1'b1, 0);
            begin
                repeat (PUSH_LAT) @(negedge clk);
                #1 check("a5_before_push", rd_data, 16'h0000);
                @(negedge clk);
                #1 check("a5_at_push", rd_data, 16'h0001);
            end
        join
        read_check(DATA_A, 16'h00A5, "a5_data");
        pop_check(8'hA5, "a5_pop");
        read_check(STAT_A, 16'h0000, "a5_after_pop");

        // Glitch shorter than half a bit
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_idle", {13'b0, dbg_state}, 16'h0000);
        read_check(STAT_A, 16'h0000, "glitch_status");
        send_byte(8'h5A, 1'b1, 0);
        pop_check(8'h5A, "glitch_next_byte");

        // Overflow: 17 pushes, no pops
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1, 0);
        read_check(STAT_A, 16'h0003, "ovf_status");
        for (int i = 0; i < 16; i++) pop_check(8'(i), "ovf_pop");
        read_check(STAT_A, 16'h0002, "ovf_drained");
        write_reg(STAT_A, 16'h0002);
        read_check(STAT_A, 16'h0000, "ovf_cleared");

        // 17th push coinciding with a pop keeps the FIFO full without overflow
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1'b1, 0);
        fork
            send_byte(8'h30, 1'b1, 0);
            begin
                repeat (PUSH_LAT) @(negedge clk);
                address_m = DATA_A;
                load_m    = 1'b1;
                @(negedge clk);
                load_m    = 1'b0;
                address_m = STAT_A;
            end
        join
        read_check(STAT_A, 16'h0001, "popsame_status");
        for (int i = 1; i <= 16; i++) pop_check(8'(8'h20 + i), "popsame_pop");
        read_check(STAT_A, 16'h0000, "popsame_empty");

        // Framing error, then recovery
        send_byte(8'h3C, 1'b0, 2);
        read_check(STAT_A, 16'h0004, "ferr_status");
        send_byte(8'h55, 1'b1, 0);
        read_check(STAT_A, 16'h0005, "ferr_then_byte");
        read_check(DATA_A, 16'h0055, "ferr_data");

        // Reset during data bit 4 of a frame carrying 0xE7
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = ((8'hE7 >> i) & 8'h01) != 8'h00;
            repeat (10) @(negedge clk);
        end
        uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h81, 1'b1, 0);
        read_check(STAT_A, 16'h0001, "midrst_status");
        pop_check(8'h81, "midrst_data");
        read_check(STAT_A, 16'h0000, "midrst_single");

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hack_uart_rx.md
Name: hack_uart_rx

Overview:
- Memory-mapped UART receiver for the Hack computer. It is the receive-side counterpart of the computer's serial transmit path.
- Deserialises 8N1 frames from uart_rx into a byte FIFO.
- Exposes a DATA register and a STATUS register on the Hack data-memory bus, in the I/O page above KBD.
- The CPU reads bytes through in_m and pops them with a store.

Parameters:
- CLK_HZ, 27000000, system clock frequency in Hz
- BAUD, 115200, line rate in bit/s
- FIFO_DEPTH, 16, byte entries; power of two, minimum 2
- DATA_ADDR, 16'h6003, address of the RX data register
- STATUS_ADDR, 16'h6002, address of the RX status register

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- uart_rx  in  1  asynchronous serial input, idles high
- address_m  in  16  CPU data-memory address
- out_m  in  16  CPU write data
- load_m  in  1  CPU write strobe, qualified by clk
- rd_data  out  16  read data for the in_m mux
- rd_hit  out  1  1 when address_m equals DATA_ADDR or STATUS_ADDR

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-low: on the rising edge of clk with reset==0, the whole block resets.
- Reset state:
  - FSM goes to IDLE; counters cleared.
  - FIFO emptied; flags ovf and ferr cleared.
  - Both synchroniser flops preset to 1.
- Input synchroniser: uart_rx passes through two flops to give rx_s, before any use.
- Bit period: DIV = (CLK_HZ + BAUD/2) / BAUD, integer. A counter reloads on every state transition.
- FSM states IDLE, START, DATA, STOP, WAIT_IDLE:
  - IDLE: on rx_s==0, go to START.
  - START: after DIV/2 cycles, sample rx_s.
    - 0: go to DATA, bit index 0.
    - 1: glitch; return to IDLE with no flag.
  - DATA: sample every DIV cycles, LSB first, into a shift register. After bit 7, go to STOP.
  - STOP: sample after DIV cycles.
    - 1: push the byte and go to IDLE.
    - 0: set ferr, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: go to IDLE on the first rx_s==1.
- Push timing: the byte is visible in the FIFO the cycle after the stop-bit sample, DIV/2 + 9*DIV cycles after rx_s falls.
- Register reads (combinational; no read side effects):
  - address_m==DATA_ADDR: rd_data = {8'h00, head byte} if non-empty, else 16'h0000.
  - address_m==STATUS_ADDR: rd_data = {13'b0, ferr, ovf, not_empty}.
  - Any other address: rd_data = 16'h0000 and rd_hit = 0.
- Register writes:
  - load_m with DATA_ADDR pops the head. The value of out_m is ignored. A pop on an empty FIFO is ignored.
  - load_m with STATUS_ADDR: out_m[1]=1 clears ovf; out_m[2]=1 clears ferr. Other bits are ignored.
- FIFO:
  - Read and write pointers are log2(FIFO_DEPTH) bits wide and wrap modulo depth.
  - Full/empty is tracked with a count of log2(FIFO_DEPTH)+1 bits.
  - Push while full (and no pop that cycle): the byte is dropped and ovf is set.
  - Push and pop in the same cycle: the pop is applied first, so the push always succeeds and the count is unchanged.
- Simultaneous events:
  - If a status clear coincides with a new ovf/ferr event in the same cycle, set wins.
  - Reset mid-frame aborts the frame; the partial byte is never pushed.

Optional Feature:
- Macro: HACK_UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: an even-parity bit is sampled DIV cycles after bit 7, and STOP follows it.
  - A parity mismatch sets sticky flag perr (STATUS bit 3) and discards the byte; the FSM still checks the stop bit.
  - out_m[3]=1 written to STATUS_ADDR clears perr.
- Not defined: 8N1 framing; STATUS bit 3 reads 0.

Test Plan:
All scenarios use CLK_HZ=1000000, BAUD=100000, so DIV=10.
1. Reset: hold reset=0 for 3 cycles with uart_rx=1, then release -> reading STATUS gives 0x0000, reading DATA gives 0x0000, rd_hit=1 at both addresses and 0 at 0x6000.
2. Single byte: send 0xA5 8N1 -> STATUS=0x0001 exactly 95 cycles after rx_s falls, DATA=0x00A5; write DATA_ADDR -> next cycle STATUS=0x0000.
3. Glitch: drive uart_rx low for 3 cycles, then high -> no push, STATUS stays 0x0000, FSM back in IDLE; a following 0x5A is received intact.
4. Overflow: send 0x00..0x10 (17 bytes) with no pops -> STATUS=0x0003; 16 pops return 0x00..0x0F and 0x10 is lost; write 0x0002 to STATUS_ADDR -> STATUS=0x0000. A pop issued in the same cycle as the 17th push instead keeps the FIFO full and ovf=0.
5. Framing error: send 0x3C with stop bit 0, holding the line low for 2 extra bit times -> STATUS=0x0004 and FIFO empty; after the line returns high, 0x55 is received and STATUS=0x0005.
6. Reset mid-frame: pulse reset=0 during data bit 4, idle the line for 20 cycles, then send 0x81 -> exactly one byte, 0x81, in the FIFO, with ovf=0 and ferr=0.
